// File: rtl/mavg_fifo_ctrl_pkg.sv
// mavg_pkg: shared state encoding and sizing helper for the moving-average FIFO controller
// Contents: state_e (IDLE/FETCH/UPDATE/OUTPUT), sum_width() for the running-sum register width
package mavg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2,
        OUTPUT = 2'd3
    } state_e;

    // A window of 2^w samples of d bits sums to less than 2^(d+w), so this width never overflows
    function automatic int sum_width(input int d, input int w);
        return d + w;
    endfunction

endpackage

// File: rtl/mavg_fifo_ctrl_if.sv
// mavg_fifo_ctrl_if: FIFO read port plus average valid/ready handshake
// master: the controller (pops the FIFO, drives the average)
// slave : the environment (FIFO flags/data, consumer ready)
interface mavg_fifo_ctrl_if #(parameter int D_SIZE = 8);
    logic              fifo_empty;
    logic [D_SIZE-1:0] fifo_data;
    logic              fifo_inc;
    logic [D_SIZE-1:0] avg_data;
    logic              avg_valid;
    logic              avg_ready;
    modport master (input fifo_empty, fifo_data, avg_ready, output fifo_inc, avg_data, avg_valid);
    modport slave (output fifo_empty, fifo_data, avg_ready, input fifo_inc, avg_data, avg_valid);
endinterface

// File: rtl/mavg_fifo_ctrl_window.sv
// mavg_window: sliding window of 2^WIN_LOG2 samples with running sum, fill count and primed flag
// Ports: i_clk, i_rstn (sync, active-low), i_shift (push i_sample), i_clear (empty the window),
//        o_sum_next (sum after pushing i_sample), o_full_next (window full after the push), o_primed
module mavg_window
    import mavg_pkg::*;
#(
    parameter int D_SIZE   = 8,
    parameter int WIN_LOG2 = 2,
    localparam int SW      = sum_width(D_SIZE, WIN_LOG2)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_shift,
    input  logic              i_clear,
    input  logic [D_SIZE-1:0] i_sample,
    output logic [SW-1:0]     o_sum_next,
    output logic              o_full_next,
    output logic              o_primed
);
    localparam int WIN = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2:0] WIN_C = (WIN_LOG2 + 1)'(WIN);
    logic [D_SIZE-1:0] win_q [WIN];
    logic [SW-1:0]     sum_q;
    logic [WIN_LOG2:0] fill_q, fill_d;
    logic [D_SIZE-1:0] oldest;
    assign o_primed    = fill_q == WIN_C;
    assign oldest      = o_primed ? win_q[WIN-1] : '0;
    assign o_sum_next  = sum_q + SW'(i_sample) - SW'(oldest);
    assign fill_d      = o_primed ? fill_q : fill_q + (WIN_LOG2 + 1)'(1);
    assign o_full_next = fill_d == WIN_C;
    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_clear) begin
            sum_q  <= '0;
            fill_q <= '0;
            for (int i = 0; i < WIN; i++) win_q[i] <= '0;
        end else if (i_shift) begin
            win_q[0] <= i_sample;
            for (int i = 1; i < WIN; i++) win_q[i] <= win_q[i-1];
            sum_q  <= o_sum_next;
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/mavg_fifo_ctrl.sv
// mavg_fifo_ctrl: drains a show-ahead FIFO one sample at a time and emits the sliding-window average
// Ports: i_clk, i_rstn (sync, active-low), i_en (allow new fetches), i_clr (sync window clear),
//        bus (mavg_fifo_ctrl_if.master: FIFO empty/data/pop, average data/valid/ready),
//        o_primed (window full), o_busy (FSM not idle)
// Build option: define MAVG_ROUND_EN for round-half-up averaging; truncating otherwise
module mavg_fifo_ctrl
    import mavg_pkg::*;
#(
    parameter int D_SIZE   = 8,
    parameter int WIN_LOG2 = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_en,
    input  logic                   i_clr,
    mavg_fifo_ctrl_if.master       bus,
    output logic                   o_primed,
    output logic                   o_busy
);
    localparam int SW = sum_width(D_SIZE, WIN_LOG2);
    state_e            state_q, state_d;
    logic [D_SIZE-1:0] sample_q, avg_q;
    logic [SW-1:0]     sum_next, rnd_sum;
    logic              full_next, pop, shift;
    assign pop   = state_q == FETCH && !bus.fifo_empty && !i_clr;
    assign shift = state_q == UPDATE && !i_clr;
`ifdef MAVG_ROUND_EN
    // Half an LSB of the quotient; zero when the window is a single sample
    localparam logic [SW-1:0] HALF = (SW'(1) << WIN_LOG2) >> 1;
    assign rnd_sum = sum_next + HALF;
`else
    assign rnd_sum = sum_next;
`endif
    mavg_window #(.D_SIZE(D_SIZE), .WIN_LOG2(WIN_LOG2)) u_window (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_shift     (shift),
        .i_clear     (i_clr),
        .i_sample    (sample_q),
        .o_sum_next  (sum_next),
        .o_full_next (full_next),
        .o_primed    (o_primed)
    );
    always_comb begin
        state_d = state_q;
        if (i_clr) state_d = IDLE;
        else case (state_q)
            IDLE:    if (i_en && !bus.fifo_empty) state_d = FETCH;
            FETCH:   if (!bus.fifo_empty) state_d = UPDATE;
            UPDATE:  state_d = full_next ? OUTPUT : IDLE;
            OUTPUT:  if (bus.avg_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            sample_q <= '0;
            avg_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pop) sample_q <= bus.fifo_data;
            if (shift) avg_q <= D_SIZE'(rnd_sum >> WIN_LOG2);
        end
    end
    assign bus.fifo_inc  = pop;
    assign bus.avg_valid = state_q == OUTPUT;
    assign bus.avg_data  = avg_q;
    assign o_busy        = state_q != IDLE;
endmodule
